// File: rtl/snake_vga_pkg.sv
// Shared types and constants for the snake game VGA read side:
// cell codes, palette, default 640x480 timing and grid geometry.
package snake_vga_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } cell_t;

    localparam logic [11:0] COL_EMPTY = 12'h000;
    localparam logic [11:0] COL_BODY  = 12'h0F0;
    localparam logic [11:0] COL_HEAD  = 12'h0A0;
    localparam logic [11:0] COL_FOOD  = 12'hF00;
    localparam logic [11:0] COL_GRID  = 12'h222;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_TILE_SHIFT = 4;
    localparam int CNT_W        = 10;

    localparam int GRID_W = VGA_H_ACTIVE >> VGA_TILE_SHIFT;
    localparam int GRID_H = VGA_V_ACTIVE >> VGA_TILE_SHIFT;

    // Per-pixel side-band that travels alongside the RAM read.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
        logic bound;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0, bound: 1'b0};

    function automatic logic [11:0] colour(input cell_t c);
        case (c)
            BODY:    return COL_BODY;
            HEAD:    return COL_HEAD;
            FOOD:    return COL_FOOD;
            default: return COL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/en_dff.sv
// Generic clock-enabled register with synchronous active-high reset to a
// parameterised value.
module en_dff #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: reset wins over enable so a held pipeline still clears immediately.
    always_ff @(posedge clk) begin
        if (reset)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/vga_timing.sv
// Stage-0 raster counters with combinational hsync/vsync/active decode;
// counters advance only on pix_en.
module vga_timing
    import snake_vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vsync  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

endmodule

// File: rtl/tile_scanout.sv
// VGA scan-out of the snake tile grid: RAM address generation, sync/active
// delay line and colour lookup. Optional grid overlay: TILE_SCANOUT_GRID_LINES_EN.
module tile_scanout
    import snake_vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int TILE_SHIFT = VGA_TILE_SHIFT,
    parameter int ADDR_W     = 11,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic [11:0]       rgb,
    output logic              frame_start
);

    // Side-band stages between the counters and the output register.
    localparam int DEPTH = 1 + RD_LAT;
    localparam logic [15:0] GRID_W_L = 16'(H_ACTIVE >> TILE_SHIFT);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             act0, hs0, vs0;
    pipe_t            s0, last;
    pipe_t            pipe [DEPTH+1];
    logic [11:0]      pix_rgb;

    // Row base as a sum of shifted copies, one per set bit of the grid width.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++)
            if (GRID_W_L[i]) acc = acc + (row << i);
        return acc;
    endfunction

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .active(act0), .hsync(hs0), .vsync(vs0)
    );

    always_comb begin
        s0        = PIPE_IDLE;
        s0.active = act0;
        s0.hs     = hs0;
        s0.vs     = vs0;
        s0.first  = (h_cnt == '0) && (v_cnt == '0);
`ifdef TILE_SCANOUT_GRID_LINES_EN
        s0.bound  = (h_cnt[TILE_SHIFT-1:0] == '0) || (v_cnt[TILE_SHIFT-1:0] == '0);
`endif
    end

    assign rd_en = pix_en;

    // Address only tracks visible pixels; in blanking it parks on the last one.
    always_ff @(posedge clk) begin
        if (reset)
            rd_addr <= '0;
        else if (pix_en && act0)
            rd_addr <= row_base(ADDR_W'(v_cnt >> TILE_SHIFT)) + ADDR_W'(h_cnt >> TILE_SHIFT);
    end

    assign pipe[0] = s0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_delay
        en_dff #(.W($bits(pipe_t)), .RST_VAL(PIPE_IDLE)) u_stage (
            .clk(clk), .reset(reset), .en(pix_en), .d(pipe[g]), .q(pipe[g+1])
        );
    end

    assign last = pipe[DEPTH];

    always_comb begin
        pix_rgb = COL_EMPTY;
        if (last.active) begin
            pix_rgb = colour(cell_t'(rd_data));
`ifdef TILE_SCANOUT_GRID_LINES_EN
            if (last.bound && cell_t'(rd_data) == EMPTY)
                pix_rgb = COL_GRID;
`endif
        end
    end

`ifndef TILE_SCANOUT_GRID_LINES_EN
    logic unused_bound;
    assign unused_bound = last.bound;
`endif

    en_dff #(.W(12), .RST_VAL(12'h000)) u_rgb (
        .clk(clk), .reset(reset), .en(pix_en), .d(pix_rgb), .q(rgb)
    );
    en_dff #(.W(1), .RST_VAL(1'b1)) u_hsync (
        .clk(clk), .reset(reset), .en(pix_en), .d(last.hs), .q(hsync)
    );
    en_dff #(.W(1), .RST_VAL(1'b1)) u_vsync (
        .clk(clk), .reset(reset), .en(pix_en), .d(last.vs), .q(vsync)
    );

    // A single-clk pulse, so unlike the other outputs it does not hold between strobes.
    always_ff @(posedge clk) begin
        if (reset)
            frame_start <= 1'b0;
        else
            frame_start <= pix_en && last.first;
    end

endmodule

// File: tb/tb_tile_scanout.sv
// Scoreboard bench for tile_scanout: random grid RAM contents, a pixel-index
// reference model, free-run / 1-of-4 strobe / mid-frame reset phases.
module tb_tile_scanout;

    localparam int HA = 640, HFP = 16, HS = 96, HT = 800;
    // Short vertical timing keeps a whole frame within the run budget.
    localparam int VA = 48, VFP = 4, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
    localparam int TILE = 16, GW = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b1;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [1:0]  rd_data = 2'd0;
    logic        hsync, vsync, frame_start;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    tile_scanout #(
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .frame_start(frame_start)
    );

    // Grid RAM with one-strobe synchronous read latency.
    logic [1:0] mem [2048];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [10:0] addr;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   checks = 0, failures = 0;
    int   n = 0;
    logic [10:0] m_addr = '0;
    bit   seg_a = 0;
    int   fs_cnt = 0, vs_low = 0, hs_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_colour(input logic [1:0] code, input bit on_line);
`ifdef TILE_SCANOUT_GRID_LINES_EN
        if (code == 2'd0 && on_line) return 12'h222;
`endif
        if (on_line) begin end
        case (code)
            2'd1:    return 12'h0F0;
            2'd2:    return 12'h0A0;
            2'd3:    return 12'hF00;
            default: return 12'h000;
        endcase
    endfunction

    // Expected outputs after the next strobe; pixel index p maps to (p mod HT, p div HT).
    task automatic model_strobe();
        int p, x, y;
        exp_t e;
        x = n % HT;
        y = (n / HT) % VT;
        if (x < HA && y < VA) m_addr = 11'((y / TILE) * GW + x / TILE);
        n++;
        e.addr = m_addr;
        p = n - 3;
        if (p < 0) begin
            e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
        end else begin
            x = p % HT;
            y = (p / HT) % VT;
            e.hs = !(x >= HA + HFP && x < HA + HFP + HS);
            e.vs = !(y >= VA + VFP && y < VA + VFP + VS);
            e.fs = (x == 0 && y == 0);
            e.rgb = (x < HA && y < VA)
                  ? ref_colour(mem[(y / TILE) * GW + x / TILE], (x % TILE == 0) || (y % TILE == 0))
                  : 12'h000;
        end
        q.push_back(e);
    endtask

    task automatic drive(input bit en);
        @(negedge clk);
        reset  = 1'b0;
        pix_en = en;
        if (en) model_strobe();
    endtask

    task automatic apply_reset(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            reset  = 1'b1;
            pix_en = 1'b1;
        end
        n = 0;
        m_addr = '0;
    endtask

    // Monitor: pop on every strobe, check hold on idle clks, reset values under reset.
    logic en_q = 1'b0, rst_q = 1'b0;
    always @(posedge clk) begin
        en_q  <= pix_en;
        rst_q <= reset;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_q) begin
            check("reset_rgb", rgb, 12'h000);
            check("reset_hsync", hsync, 1);
            check("reset_vsync", vsync, 1);
            check("reset_rd_addr", rd_addr, 0);
            check("reset_frame_start", frame_start, 0);
            last_exp = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0, addr: 11'd0};
        end else if (en_q) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: strobe with no expected entry at t=%0t", $time);
            end else begin
                e = q.pop_front();
                check("rgb", rgb, e.rgb);
                check("hsync", hsync, e.hs);
                check("vsync", vsync, e.vs);
                check("frame_start", frame_start, e.fs);
                check("rd_addr", rd_addr, e.addr);
                last_exp = e;
                if (seg_a) begin
                    if (frame_start) fs_cnt++;
                    if (!vsync) vs_low++;
                    if (!hsync) hs_low++;
                end
            end
        end else begin
            check("hold_rgb", rgb, last_exp.rgb);
            check("hold_hsync", hsync, last_exp.hs);
            check("hold_vsync", vsync, last_exp.vs);
            check("hold_rd_addr", rd_addr, last_exp.addr);
            check("idle_frame_start", frame_start, 0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL timeout: bench did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        for (int i = 0; i < 2048; i++) mem[i] = 2'($urandom_range(0, 3));
        mem[81] = 2'd3;  // tile of pixel (17,35) holds FOOD
        mem[2]  = 2'd0;  // tile of pixels (32,5) and (33,5) is EMPTY

        apply_reset(5);

        // Free run over a full frame plus a little of the next.
        seg_a = 1;
        repeat (VT * HT + 200) drive(1);
        drive(0);
        drive(0);
        seg_a = 0;
        check("frame_start_pulses", fs_cnt, 2);
        check("vsync_low_strobes", vs_low, VS * HT);
        check("hsync_low_strobes", hs_low, VT * HS);

        // One strobe every four clks must reproduce the same per-strobe sequence.
        apply_reset(2);
        for (int i = 0; i < 2000; i++) begin
            drive(1);
            repeat (3) drive(0);
        end

        // Reset while the pipeline is full of visible pixels at (300,20).
        apply_reset(3);
        repeat (20 * HT + 300) drive(1);
        apply_reset(4);
        repeat (1000) drive(1);
        drive(0);
        drive(0);
        check("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_scanout.md
Name: tile_scanout

Overview:
- VGA read side of the snake game grid. The game logic writes tile cells into grid RAM; this block reads them back during raster scan.
- Generates 640x480 VGA timing, issues grid-RAM read addresses per pixel, and maps the returned cell code to 12-bit RGB.
- hsync/vsync are aligned to the pipelined pixel data.
- Sits between grid RAM (synchronous read port) and the FPGA VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- TILE_SHIFT, 4, log2 of tile edge in pixels (16 px tiles give a 40x30 grid)
- ADDR_W, 11, grid-RAM address width
- RD_LAT, 1, grid-RAM read latency in pix_en strobes (1..2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe; the whole pipeline advances only when high
- rd_en  out  1  grid-RAM read enable, equal to pix_en
- rd_addr  out  ADDR_W  grid cell index
- rd_data  in  2  cell code from RAM; holds its value when rd_en is low
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  12  4:4:4 pixel colour, R in [11:8]
- frame_start  out  1  one-clk pulse when output pixel (0,0) is presented

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: h_cnt=0, v_cnt=0, rd_addr=0, rgb=0, hsync=1, vsync=1, frame_start=0. All delay-pipeline stages are cleared to the blanked, sync-inactive state.
- Reset mid-frame restarts at (0,0) on the next pix_en. No partial colour may leak out of the pipeline.
- Counters (stage 0), on pix_en:
  - h_cnt wraps at H_TOTAL-1 = 799.
  - v_cnt increments on h wrap and wraps at V_TOTAL-1 = 524.
- Stage 1, on pix_en:
  - rd_addr <= (v_cnt>>TILE_SHIFT)*GRID_W + (h_cnt>>TILE_SHIFT), where GRID_W = H_ACTIVE>>TILE_SHIFT.
  - Implement the multiply with shift-add (for 40: <<5 + <<3).
  - During blanking, rd_addr holds its last value (don't-care, but no X).
- Stage 1+RD_LAT: rd_data is valid for that pixel.
- Output register, stage L = 2+RD_LAT (3 at default):
  - rgb <= colour(rd_data) when the delayed active flag is set, else 0.
- Sync alignment:
  - hsync, vsync and active flag are computed at stage 0 and delayed through L pix_en stages.
  - hsync low for h in [656,751] (stage-0 coordinate).
  - vsync low for v in [490,491].
- frame_start: high for exactly one clk, the clk on which the delayed (h,v)=(0,0) reaches the output register.
- Colour map (cell_t):
  - EMPTY=0 → 12'h000
  - BODY=1 → 12'h0F0
  - HEAD=2 → 12'h0A0
  - FOOD=3 → 12'hF00
- pix_en low: every register holds. Outputs are stable with no glitch or duplicate advance.
- rd_addr never exceeds GRID_W*GRID_H-1 (1199) while active.

Optional Feature:
- Macro: TILE_SCANOUT_GRID_LINES_EN
- Defined: active pixels with (x mod tile==0 or y mod tile==0) and cell EMPTY output 12'h222. Non-empty cells are unaffected.
- Undefined: no grid overlay, no extra logic.
- Boundary flag is computed at stage 0 and delayed with the sync pipeline.

Decomposition:
- Package snake_vga_pkg holds:
  - cell_t enum (2-bit)
  - colour constants COL_EMPTY, COL_BODY, COL_HEAD, COL_FOOD, COL_GRID
  - default VGA timing constants
  - GRID_W/GRID_H
- One sub-module: vga_timing (h/v counters, hsync/vsync/active generation, pix_en gated).
- The delay pipeline is built from the team's generic enabled reset flops, with pix_en as enable.

Test Plan:
- Reset held 5 clks with pix_en=1 → hsync=1, vsync=1, rgb=0, rd_addr=0, frame_start=0 throughout.
- Free-run pix_en=1, one line → hsync low for exactly 96 strobes starting 656+3 strobes after the line's h=0. Period is 800 strobes.
- Full frame → vsync low for 2 lines (1600 strobes). frame_start pulses once per 420000 strobes.
- Pixel (x=17, y=35) → rd_addr=81. RAM returns FOOD → rgb=F00 exactly 3 strobes after the counter reached (17,35). Blanking pixel x=700 → rgb=0 regardless of rd_data.
- pix_en toggled 1-of-4 clks → identical output sequence per strobe as the free-run case. Outputs hold between strobes.
- Reset asserted at (h=300, v=200) → next strobes restart at (0,0), no stale colour emitted. With TILE_SCANOUT_GRID_LINES_EN, pixel (32,5) EMPTY → rgb=222, and (33,5) EMPTY → rgb=000.
